// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - chess clock turn sequencer: timer enables, per-move bonus pulses, pause and result latch
// Every output is registered from the next-state logic, so a qualifying input at one edge shows up right after it.

module turn_controller #(
  parameter int INC_SEC  = 5,
  parameter int DEBOUNCE = 16,
  parameter int PLY_W    = 10
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_ce,
  input  logic             i_start,
  input  logic             i_select,
  input  logic             i_stop,
  input  logic             i_overflow1,
  input  logic             i_overflow2,
  output logic             o_enable_p1,
  output logic             o_enable_p2,
  output logic             o_load,
  output logic             o_bonus_p1,
  output logic             o_bonus_p2,
  output logic             o_paused,
  output logic             o_end,
  output logic [1:0]       o_winner,
  output logic [PLY_W-1:0] o_ply
);

  localparam int              DB_W     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_LOAD  = DB_W'(DEBOUNCE - 1);
  localparam logic [5:0]      INC_LOAD = 6'(INC_SEC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_P1,
    S_RUN_P2,
    S_BONUS,
    S_PAUSED,
    S_GAME_OVER
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_start_d, r_select_d, r_stop_d;
  logic [DB_W-1:0]  r_db_cnt, w_db_cnt_nxt, w_db_dec;
  logic [5:0]       r_bonus_cnt, w_bonus_cnt_nxt;
  logic             r_mover_p2, w_mover_p2_nxt;
  logic             r_resume_p2, w_resume_p2_nxt;

  logic             r_enable_p1, r_enable_p2, r_load, r_bonus_p1, r_bonus_p2, r_paused, r_end;
  logic [1:0]       r_winner;
  logic [PLY_W-1:0] r_ply;

  logic             w_enable_p1_nxt, w_enable_p2_nxt, w_load_nxt, w_bonus_p1_nxt, w_bonus_p2_nxt;
  logic             w_paused_nxt, w_end_nxt;
  logic [1:0]       w_winner_nxt;
  logic [PLY_W-1:0] w_ply_nxt;

  logic w_start_edge, w_select_edge, w_stop_edge, w_overflow, w_select_ok, w_in_game;

  assign w_start_edge  = i_start & ~r_start_d;
  assign w_select_edge = i_select & ~r_select_d;
  assign w_stop_edge   = i_stop & ~r_stop_d;
  assign w_overflow    = i_overflow1 | i_overflow2;
  assign w_select_ok   = w_select_edge && (r_db_cnt == '0);
  assign w_db_dec      = (r_db_cnt != '0) ? r_db_cnt - 1'b1 : '0;
  assign w_in_game     = r_state inside {S_RUN_P1, S_RUN_P2, S_BONUS, S_PAUSED};

  always_comb begin
    w_state_nxt     = r_state;
    w_db_cnt_nxt    = w_db_dec;
    w_bonus_cnt_nxt = r_bonus_cnt;
    w_mover_p2_nxt  = r_mover_p2;
    w_resume_p2_nxt = r_resume_p2;
    w_load_nxt      = 1'b0;
    w_bonus_p1_nxt  = 1'b0;
    w_bonus_p2_nxt  = 1'b0;
    w_paused_nxt    = r_paused;
    w_end_nxt       = r_end;
    w_winner_nxt    = r_winner;
    w_ply_nxt       = r_ply;
    w_enable_p1_nxt = 1'b0;
    w_enable_p2_nxt = 1'b0;

    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (w_start_edge) begin
          w_state_nxt  = S_RUN_P1;
          w_load_nxt   = 1'b1;
          w_ply_nxt    = '0;
          w_end_nxt    = 1'b0;
          w_winner_nxt = 2'b00;
        end
      end
      S_RUN_P1, S_RUN_P2: begin
        if (w_stop_edge) begin
          w_state_nxt     = S_PAUSED;
          w_paused_nxt    = 1'b1;
          w_resume_p2_nxt = (r_state == S_RUN_P2);
        end else if (w_select_ok) begin
          w_ply_nxt    = (&r_ply) ? r_ply : r_ply + 1'b1;
          w_db_cnt_nxt = DB_LOAD;
          if (INC_SEC > 0) begin
            w_state_nxt     = S_BONUS;
            w_bonus_cnt_nxt = INC_LOAD;
            w_mover_p2_nxt  = (r_state == S_RUN_P2);
            w_bonus_p1_nxt  = (r_state == S_RUN_P1);
            w_bonus_p2_nxt  = (r_state == S_RUN_P2);
          end else begin
            w_state_nxt = (r_state == S_RUN_P1) ? S_RUN_P2 : S_RUN_P1;
          end
        end
      end
      S_BONUS: begin
        // The counter holds pulses not yet retired; the first pulse went out on entry.
        if (r_bonus_cnt > 6'd1) begin
          w_bonus_cnt_nxt = r_bonus_cnt - 6'd1;
          w_bonus_p1_nxt  = ~r_mover_p2;
          w_bonus_p2_nxt  = r_mover_p2;
        end else begin
          w_bonus_cnt_nxt = 6'd0;
          w_state_nxt     = r_mover_p2 ? S_RUN_P1 : S_RUN_P2;
        end
      end
      S_PAUSED: begin
        if (w_stop_edge) begin
          w_paused_nxt = 1'b0;
          w_state_nxt  = r_resume_p2 ? S_RUN_P2 : S_RUN_P1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_in_game && w_overflow) begin
      w_state_nxt     = S_GAME_OVER;
      w_end_nxt       = 1'b1;
      w_winner_nxt    = {i_overflow1, i_overflow2};
      w_paused_nxt    = 1'b0;
      w_bonus_cnt_nxt = 6'd0;
      w_bonus_p1_nxt  = 1'b0;
      w_bonus_p2_nxt  = 1'b0;
      w_ply_nxt       = r_ply;
      w_db_cnt_nxt    = w_db_dec;
    end

    // Timers stay stopped during the LOAD cycle so they start from the freshly loaded time.
    w_enable_p1_nxt = (w_state_nxt == S_RUN_P1) && !w_load_nxt;
    w_enable_p2_nxt = (w_state_nxt == S_RUN_P2) && !w_load_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state     <= S_IDLE;
      r_start_d   <= 1'b0;
      r_select_d  <= 1'b0;
      r_stop_d    <= 1'b0;
      r_db_cnt    <= '0;
      r_bonus_cnt <= 6'd0;
      r_mover_p2  <= 1'b0;
      r_resume_p2 <= 1'b0;
      r_enable_p1 <= 1'b0;
      r_enable_p2 <= 1'b0;
      r_load      <= 1'b0;
      r_bonus_p1  <= 1'b0;
      r_bonus_p2  <= 1'b0;
      r_paused    <= 1'b0;
      r_end       <= 1'b0;
      r_winner    <= 2'b00;
      r_ply       <= '0;
    end else if (!i_ce) begin
      r_enable_p1 <= 1'b0;
      r_enable_p2 <= 1'b0;
      r_load      <= 1'b0;
      r_bonus_p1  <= 1'b0;
      r_bonus_p2  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_d   <= i_start;
      r_select_d  <= i_select;
      r_stop_d    <= i_stop;
      r_db_cnt    <= w_db_cnt_nxt;
      r_bonus_cnt <= w_bonus_cnt_nxt;
      r_mover_p2  <= w_mover_p2_nxt;
      r_resume_p2 <= w_resume_p2_nxt;
      r_enable_p1 <= w_enable_p1_nxt;
      r_enable_p2 <= w_enable_p2_nxt;
      r_load      <= w_load_nxt;
      r_bonus_p1  <= w_bonus_p1_nxt;
      r_bonus_p2  <= w_bonus_p2_nxt;
      r_paused    <= w_paused_nxt;
      r_end       <= w_end_nxt;
      r_winner    <= w_winner_nxt;
      r_ply       <= w_ply_nxt;
    end
  end

  assign o_enable_p1 = r_enable_p1;
  assign o_enable_p2 = r_enable_p2;
  assign o_load      = r_load;
  assign o_bonus_p1  = r_bonus_p1;
  assign o_bonus_p2  = r_bonus_p2;
  assign o_paused    = r_paused;
  assign o_end       = r_end;
  assign o_winner    = r_winner;
  assign o_ply       = r_ply;

endmodule

// File: tb/tb_turn_controller.sv
// tb/tb_turn_controller.sv - bench for turn_controller: directed game scenarios then random play against a game-level model

module tb_turn_controller;

  localparam int INC_SEC  = 5;
  localparam int DEBOUNCE = 16;
  localparam int PLY_W    = 10;

  logic clk = 1'b0;
  logic clr = 1'b0, ce = 1'b1, start = 1'b0, sel = 1'b0, stp = 1'b0, ov1 = 1'b0, ov2 = 1'b0;
  logic en1, en2, load, b1, b2, paused, game_end;
  logic [1:0]       winner;
  logic [PLY_W-1:0] ply;

  turn_controller #(.INC_SEC(INC_SEC), .DEBOUNCE(DEBOUNCE), .PLY_W(PLY_W)) dut (
    .i_clk(clk), .i_clr(clr), .i_ce(ce), .i_start(start), .i_select(sel), .i_stop(stp),
    .i_overflow1(ov1), .i_overflow2(ov2),
    .o_enable_p1(en1), .o_enable_p2(en2), .o_load(load), .o_bonus_p1(b1), .o_bonus_p2(b2),
    .o_paused(paused), .o_end(game_end), .o_winner(winner), .o_ply(ply)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Game-level model: who is on move, whether a game is live, pulses still owed.
  bit   m_prev_start = 0, m_prev_sel = 0, m_prev_stop = 0;
  int   m_db = 0, m_turn = 1, m_due = 0, m_ply = 0;
  bit   m_playing = 0, m_in_bonus = 0, m_paused = 0, m_end = 0;
  logic [1:0] m_winner = 2'b00;
  logic e_en1 = 0, e_en2 = 0, e_load = 0, e_b1 = 0, e_b2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_mover();
    if (m_turn == 1) e_b1 = 1'b1;
    else             e_b2 = 1'b1;
  endtask

  task automatic model_step();
    bit se, sl, st, acc;
    if (clr) begin
      m_prev_start = 0; m_prev_sel = 0; m_prev_stop = 0;
      m_db = 0; m_turn = 1; m_due = 0; m_ply = 0;
      m_playing = 0; m_in_bonus = 0; m_paused = 0; m_end = 0; m_winner = 2'b00;
      e_en1 = 0; e_en2 = 0; e_load = 0; e_b1 = 0; e_b2 = 0;
    end else if (!ce) begin
      e_en1 = 0; e_en2 = 0; e_load = 0; e_b1 = 0; e_b2 = 0;
    end else begin
      se = start && !m_prev_start;
      sl = sel && !m_prev_sel;
      st = stp && !m_prev_stop;
      m_prev_start = start; m_prev_sel = sel; m_prev_stop = stp;
      acc  = (m_db == 0);
      m_db = (m_db > 0) ? m_db - 1 : 0;
      e_load = 0; e_b1 = 0; e_b2 = 0;
      if (!m_playing) begin
        if (se) begin
          e_load = 1; m_ply = 0; m_end = 0; m_winner = 2'b00;
          m_playing = 1; m_turn = 1; m_paused = 0; m_in_bonus = 0; m_due = 0;
        end
      end else if (ov1 || ov2) begin
        m_playing = 0; m_end = 1; m_winner = {ov1, ov2};
        m_paused = 0; m_in_bonus = 0; m_due = 0;
      end else if (m_paused) begin
        if (st) m_paused = 0;
      end else if (m_in_bonus) begin
        if (m_due > 0) begin
          pulse_mover();
          m_due--;
        end else begin
          m_in_bonus = 0;
          m_turn = 3 - m_turn;
        end
      end else if (st) begin
        m_paused = 1;
      end else if (sl && acc) begin
        m_ply = (m_ply == (1 << PLY_W) - 1) ? m_ply : m_ply + 1;
        m_db  = DEBOUNCE - 1;
        if (INC_SEC > 0) begin
          m_in_bonus = 1;
          pulse_mover();
          m_due = INC_SEC - 1;
        end else begin
          m_turn = 3 - m_turn;
        end
      end
      e_en1 = m_playing && !m_paused && !m_in_bonus && (m_turn == 1) && !e_load;
      e_en2 = m_playing && !m_paused && !m_in_bonus && (m_turn == 2) && !e_load;
    end
  endtask

  task automatic tick(input string tag);
    logic [PLY_W-1:0] exp_ply;
    @(posedge clk);
    model_step();
    #1;
    exp_ply = PLY_W'(m_ply);
    chk({tag, " outputs"},
        32'({en1, en2, load, b1, b2, paused, game_end, winner, ply}),
        32'({e_en1, e_en2, e_load, e_b1, e_b2, m_paused, m_end, m_winner, exp_ply}));
    chk({tag, " enables exclusive"}, 32'(en1 & en2), 32'd0);
  endtask

  int nb;

  initial begin
    clr = 1'b1;
    tick("reset");
    chk("reset all zero", 32'({en1, en2, load, b1, b2, paused, game_end, winner, ply}), 32'd0);
    clr = 1'b0;

    start = 1'b1; tick("start");
    chk("load on start", 32'(load), 32'd1);
    chk("p1 idle during load", 32'(en1), 32'd0);
    chk("ply cleared", 32'(ply), 32'd0);
    start = 1'b0; tick("after load");
    chk("load one cycle", 32'(load), 32'd0);
    chk("p1 running", 32'(en1), 32'd1);
    repeat (2) tick("run p1");

    sel = 1'b1; tick("move p1");
    sel = 1'b0;
    chk("p1 stopped on move", 32'(en1), 32'd0);
    nb = int'(b1);
    for (int i = 0; i < 4; i++) begin
      sel = (i == 2);
      tick("bonus p1");
      nb += int'(b1);
    end
    sel = 1'b0;
    chk("bonus p1 count", 32'(nb), 32'(INC_SEC));
    tick("to p2");
    chk("p2 running", 32'(en2), 32'd1);
    chk("bounce ignored ply", 32'(ply), 32'd1);

    stp = 1'b1; tick("pause");
    chk("paused set", 32'(paused), 32'd1);
    chk("p2 halted", 32'(en2), 32'd0);
    stp = 1'b0;
    repeat (12) tick("paused wait");
    sel = 1'b1; tick("select while paused");
    chk("select ignored paused", 32'(ply), 32'd1);
    sel = 1'b0; tick("paused");
    stp = 1'b1; tick("resume");
    chk("paused cleared", 32'(paused), 32'd0);
    chk("p2 resumed", 32'(en2), 32'd1);
    stp = 1'b0; tick("run p2");

    sel = 1'b1; tick("move p2");
    chk("bonus p2 first", 32'(b2), 32'd1);
    sel = 1'b0;
    repeat (5) tick("bonus p2");
    chk("back to p1", 32'(en1), 32'd1);
    chk("ply two", 32'(ply), 32'd2);
    repeat (16) tick("run p1");
    ov1 = 1'b1; sel = 1'b1; tick("flag p1");
    chk("end on overflow", 32'(game_end), 32'd1);
    chk("p2 wins", 32'(winner), 32'd2);
    chk("ply kept on overflow", 32'(ply), 32'd2);
    ov1 = 1'b0; sel = 1'b0; tick("game over");
    chk("end holds", 32'(game_end), 32'd1);

    start = 1'b1; tick("restart");
    chk("restart load", 32'(load), 32'd1);
    chk("restart end cleared", 32'(game_end), 32'd0);
    chk("restart winner cleared", 32'(winner), 32'd0);
    start = 1'b0; tick("restart run");
    ov1 = 1'b1; ov2 = 1'b1; tick("double flag");
    chk("draw winner", 32'(winner), 32'd3);
    ov1 = 1'b0; ov2 = 1'b0; tick("game over 2");

    start = 1'b1; tick("restart 2");
    start = 1'b0;
    repeat (16) tick("run p1");
    sel = 1'b1; tick("move bonus");
    sel = 1'b0; tick("bonus 2nd");
    chk("second pulse", 32'(b1), 32'd1);
    clr = 1'b1; ce = 1'b0; tick("clr over ce");
    chk("clr mid bonus zero", 32'({en1, en2, load, b1, b2, paused, game_end, winner, ply}), 32'd0);
    clr = 1'b0; ce = 1'b1;
    nb = 0;
    repeat (8) begin
      tick("post clr");
      nb += int'(b1);
    end
    chk("no pulses after clr", 32'(nb), 32'd0);

    start = 1'b1; tick("start 3");
    start = 1'b0; tick("run 3");
    chk("p1 running 3", 32'(en1), 32'd1);
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sel = (i == 3 || i == 4);
      tick("ce low");
      chk("enable gated by ce", 32'(en1), 32'd0);
    end
    sel = 1'b0; ce = 1'b1; tick("ce back");
    chk("p1 after ce", 32'(en1), 32'd1);
    chk("ply after ce", 32'(ply), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) start = ~start;
      if ($urandom_range(0, 3) == 0)  sel = ~sel;
      if ($urandom_range(0, 24) == 0) stp = ~stp;
      ov1 = ($urandom_range(0, 299) == 0);
      ov2 = ($urandom_range(0, 299) == 0);
      ce  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 999) == 0);
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
Game sequencer for the chess clock. It decides which player's Timer_Clock runs and loads both timers at game start. It applies a per-move time increment, handles pause/resume and latches the game result. It sits between the front-panel buttons, the two Timer_Clock instances and the decoders. It replaces the simple SELECT/STOP switch logic with a full turn state machine.

Parameters:
INC_SEC, 5, bonus seconds credited to a player after each of their moves (0 = no increment; max 63)
DEBOUNCE, 16, CLK cycles during which further SELECT edges are ignored after an accepted one (>=1)
PLY_W, 10, width of the half-move counter

Ports:
CLK  in  1  system clock
CLR  in  1  reset, synchronous, active-high
CE  in  1  global clock enable; when 0 the block freezes
START  in  1  start/restart button (level; rising edge used)
SELECT  in  1  "move done" button (level; rising edge used)
STOP  in  1  pause toggle button (level; rising edge used)
OVERFLOW1  in  1  player-1 timer expired (level)
OVERFLOW2  in  1  player-2 timer expired (level)
Enable_p1  out  1  player-1 timer run enable
Enable_p2  out  1  player-2 timer run enable
LOAD  out  1  one-cycle pulse: timers reload initial time
BONUS_p1  out  1  high one cycle per bonus second added to player 1
BONUS_p2  out  1  high one cycle per bonus second added to player 2
PAUSED  out  1  game paused
END  out  1  game over
WINNER  out  2  01 = P1, 10 = P2, 11 = simultaneous expiry, 00 = none
PLY  out  PLY_W  accepted half-moves since start

Behaviour:
- Reset: CLR is sampled at the CLK edge with priority over everything, including CE=0.
  - All outputs reset to 0; state = IDLE.
  - Edge-detect registers, debounce counter and bonus counter all reset to 0.
- Edge detection: input rising edge = input high at the current edge and low at the previous sampled edge. The previous-value registers update only when CE=1.
- All outputs are registered. A qualifying input at edge k is reflected on the outputs after edge k.
- CE=0: state, counters and edge registers hold. Enable_p1, Enable_p2, LOAD and BONUS_* are forced 0. PAUSED, END, WINNER and PLY hold.
- States: IDLE, RUN_P1, RUN_P2, BONUS, PAUSED, GAME_OVER.
- IDLE:
  - All enables are 0.
  - START edge: LOAD=1 for one cycle, PLY<=0, then go to RUN_P1.
  - SELECT and STOP are ignored.
- RUN_P1 / RUN_P2:
  - The corresponding Enable_p* is 1 and the other is 0.
  - An accepted SELECT edge does all of the following:
    - PLY increments, saturating at all-ones.
    - The debounce counter loads DEBOUNCE-1.
    - If INC_SEC>0: go to BONUS, credited to the mover, with the bonus counter = INC_SEC.
    - Otherwise: go directly to the opponent's RUN state.
- Debounce: a SELECT edge is accepted only when the debounce counter is 0. The counter decrements by 1 per CE cycle down to 0.
- BONUS:
  - Both enables are 0.
  - BONUS_p(mover)=1 every cycle while the counter is nonzero; the counter decrements each cycle.
  - On the cycle the counter reaches 0, go to the opponent's RUN state. Exactly INC_SEC pulses are emitted.
  - SELECT and STOP are ignored.
- STOP edge in RUN_Px:
  - Go to PAUSED with PAUSED=1 and both enables 0.
  - Remember which RUN state was active.
  - STOP edge in PAUSED: return to the remembered RUN state with PAUSED=0.
  - SELECT is ignored while paused.
- Overflow: in RUN_P1, RUN_P2, BONUS or PAUSED, either OVERFLOW goes to GAME_OVER.
  - WINNER = {OVERFLOW1, OVERFLOW2} mapped as: OVERFLOW1 only → 10, OVERFLOW2 only → 01, both → 11.
  - END=1, both enables 0, BONUS_* 0, PAUSED 0.
  - Priority is overflow > STOP > SELECT when they occur in the same cycle.
- GAME_OVER: outputs hold. A START edge restarts: LOAD pulse, PLY<=0, END<=0, WINNER<=00, then RUN_P1.
- START edge in any state other than IDLE or GAME_OVER is ignored (no mid-game restart; use CLR).
- Reset mid-operation (any state, including mid-BONUS): everything goes to the reset values on the next edge. Pending bonus pulses are discarded.
- At most one state transition per cycle. Enable_p1 and Enable_p2 are never both 1.

Test Plan:
- Reset, CE=1, START pulse → LOAD=1 for exactly 1 cycle, Enable_p1=1 from the next cycle, PLY=0.
- In RUN_P1 with INC_SEC=5: SELECT pulse → Enable_p1=0, BONUS_p1 high for 5 consecutive cycles, then Enable_p2=1, PLY=1. A second SELECT edge 3 cycles after the first (DEBOUNCE=16) → ignored, PLY stays 1.
- In RUN_P2: STOP edge → PAUSED=1, both enables 0; SELECT edge → no effect; STOP edge → PAUSED=0, Enable_p2=1.
- In RUN_P1: OVERFLOW1 asserted together with a SELECT edge → GAME_OVER, END=1, WINNER=10, PLY unchanged. OVERFLOW1 and OVERFLOW2 together → WINNER=11.
- In BONUS with 2 pulses emitted: CLR=1 with CE=0 → next cycle all outputs 0, state IDLE, no further BONUS pulses.
- In RUN_P1: CE held 0 for 10 cycles with a SELECT edge during that time → Enable_p1=0 while CE=0, state unchanged. CE back to 1 → Enable_p1=1, PLY unchanged.
